// File: rtl/bitbakery_pkg.sv
// Shared BitBakery constants: channel map, default 1 kHz game-clock timings, counter sizing helper.
package bitbakery_pkg;

  localparam int NUM_CH     = 8;
  localparam int CH_BOTAO0  = 0;
  localparam int CH_BOTAO1  = 1;
  localparam int CH_BOTAO2  = 2;
  localparam int CH_BOTAO3  = 3;
  localparam int CH_BOTAO4  = 4;
  localparam int CH_BOTAO5  = 5;
  localparam int CH_BOTAO6  = 6;
  localparam int CH_INICIAR = 7;

  localparam int DEB_20MS   = 20;
  localparam int HOLD_500MS = 500;
  localparam int REP_150MS  = 150;

  // Bits needed to hold values 0..max_val-1, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop sync, counter debounce, press/release/auto-repeat strobes.
// level/press/release_pulse/evento update DEBOUNCE_CYCLES+2 edges after a steady raw change; no backpressure.
module debounce_channel
  import bitbakery_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_20MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REP_150MS,
  parameter int REPEAT_EN       = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic evento
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = cnt_w(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

  logic            s1, s2;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rp_cnt;
  logic            rp_phase;

  logic            differ, flip, rise, fall, rp_hit;
  logic [RP_W-1:0] rp_limit;

  // level is the registered stable state itself (inverted), so it moves on the same edge the count completes.
  assign differ   = (s2 == level);
  assign flip     = differ && (db_cnt == DB_LAST);
  assign rise     = flip && !s2;
  assign fall     = flip && s2;
  assign rp_limit = rp_phase ? REP_LAST : HOLD_LAST;
  assign rp_hit   = (REPEAT_EN != 0) && level && !fall && (rp_cnt == rp_limit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      db_cnt        <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      evento        <= 1'b0;
      rp_cnt        <= '0;
      rp_phase      <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      press         <= rise;
      release_pulse <= fall;
      evento        <= rise | rp_hit;

      if (!differ || flip) db_cnt <= '0;
      else                 db_cnt <= db_cnt + DB_W'(1);

      if (flip) level <= ~s2;

      if (!level || fall) begin
        rp_cnt   <= '0;
        rp_phase <= 1'b0;
      end else if (rp_hit) begin
        rp_cnt   <= '0;
        rp_phase <= 1'b1;
      end else begin
        rp_cnt   <= rp_cnt + RP_W'(1);
      end
    end
  end

endmodule

// File: rtl/bitbakery_input_conditioner.sv
// Conditions the active-low pushbutton pins into clean levels and single-cycle event strobes.
// Per-channel latency DEBOUNCE_CYCLES+2 edges; first_idx/any_pressed are combinational from level; no backpressure.
module bitbakery_input_conditioner
  import bitbakery_pkg::*;
#(
  parameter int N               = NUM_CH,
  parameter int DEBOUNCE_CYCLES = DEB_20MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REP_150MS,
  parameter int REPEAT_EN       = 1,
  localparam int IDX_W          = cnt_w(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     raw_in,
  output logic [N-1:0]     level,
  output logic [N-1:0]     press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic [N-1:0]     release_pulse,
  output logic [N-1:0]     evento,
  output logic             any_pressed,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_valid
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .raw           (raw_in[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .evento        (evento[i])
    );
  end

  assign any_pressed = |level;
  assign first_valid = any_pressed;

  // Scan high to low so the lowest held index wins.
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (level[i]) first_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_bitbakery_input_conditioner.sv
// Directed bench: expected events are queued per cycle when stimulus is driven and checked every cycle.
module tb_bitbakery_input_conditioner;
  import bitbakery_pkg::*;

  localparam int N    = 8;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] level, press, release_pulse, evento;
  logic         any_pressed, first_valid;
  logic [2:0]   first_idx;

  bitbakery_input_conditioner #(
    .N               (N),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP),
    .REPEAT_EN       (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_in        (raw_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .evento        (evento),
    .any_pressed   (any_pressed),
    .first_idx     (first_idx),
    .first_valid   (first_valid)
  );

  always #5 clock = ~clock;

  typedef enum {EV_PRESS, EV_REL, EV_REP} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
    int       ch;
  } ev_t;

  ev_t          sbq[$];
  int           cyc;
  int           checks;
  int           errors;
  logic [N-1:0] exp_level;

  function automatic void push_ev(input int c, input ev_kind_t k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    sbq.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_prs, e_rls, e_evt;
    logic [2:0]   e_idx;
    e_prs = '0;
    e_rls = '0;
    e_evt = '0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        case (sbq[i].kind)
          EV_PRESS: begin
            exp_level[sbq[i].ch] = 1'b1;
            e_prs[sbq[i].ch]     = 1'b1;
            e_evt[sbq[i].ch]     = 1'b1;
          end
          EV_REL: begin
            exp_level[sbq[i].ch] = 1'b0;
            e_rls[sbq[i].ch]     = 1'b1;
          end
          default: e_evt[sbq[i].ch] = 1'b1;
        endcase
        sbq.delete(i);
      end
    end
    e_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (exp_level[i]) e_idx = 3'(i);
    chk("level",       level,         exp_level);
    chk("press",       press,         e_prs);
    chk("release",     release_pulse, e_rls);
    chk("evento",      evento,        e_evt);
    chk("first_idx",   {5'b0, first_idx},   {5'b0, e_idx});
    chk("any_pressed", {7'b0, any_pressed}, {7'b0, |exp_level});
    chk("first_valid", {7'b0, first_valid}, {7'b0, |exp_level});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      cyc++;
      #1;
      check_outputs();
    end
  endtask

  initial begin
    int p;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    exp_level = '0;

    // 1: reset with pins low, then release with pins idle-high
    reset  = 1'b0;
    raw_in = 8'h00;
    #1;
    check_outputs();
    tick(3);
    raw_in = 8'hFF;
    reset  = 1'b1;
    tick(12);

    // 2: single press on botao3, released before any repeat is due
    raw_in[CH_BOTAO3] = 1'b0;
    push_ev(cyc + DB + 2, EV_PRESS, CH_BOTAO3);
    tick(DB + 2);
    chk("press3_level", {7'b0, level[CH_BOTAO3]}, 8'h01);
    raw_in[CH_BOTAO3] = 1'b1;
    push_ev(cyc + DB + 2, EV_REL, CH_BOTAO3);
    tick(DB + 4);

    // 3: glitch of DB-1 cycles is rejected
    raw_in[CH_BOTAO0] = 1'b0;
    tick(DB - 1);
    raw_in[CH_BOTAO0] = 1'b1;
    tick(10);

    // 4/5: long hold on botao5 with auto-repeat, then release
    raw_in[CH_BOTAO5] = 1'b0;
    p = cyc + DB + 2;
    push_ev(p, EV_PRESS, CH_BOTAO5);
    for (int k = HOLD; k <= 28; k += REP) push_ev(p + k, EV_REP, CH_BOTAO5);
    tick(DB + 2 + 24);
    raw_in[CH_BOTAO5] = 1'b1;
    push_ev(p + 30, EV_REL, CH_BOTAO5);
    tick(12);

    // 6: simultaneous presses, then reset mid-hold
    raw_in[CH_BOTAO2] = 1'b0;
    raw_in[CH_BOTAO6] = 1'b0;
    push_ev(cyc + DB + 2, EV_PRESS, CH_BOTAO2);
    push_ev(cyc + DB + 2, EV_PRESS, CH_BOTAO6);
    tick(DB + 4);
    chk("dual_first_idx", {5'b0, first_idx}, 8'd2);
    chk("dual_level", level, 8'h44);
    reset     = 1'b0;
    exp_level = '0;
    #1;
    check_outputs();
    tick(3);
    raw_in = 8'hFF;
    reset  = 1'b1;
    tick(12);

    chk("pending_events", 8'(sbq.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
